pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage.
- Holds the fetch PC and advances it by one instruction per cycle.
- Honours hazard stalls, resolved branch/jump redirects and trap entry.
- Contains a return-address stack (RAS) that predicts return targets.
- Drives the instruction-memory address and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 18 +
 rtl/ras_stack.sv | 68 ++++++
 rtl/pc_gen.sv | 86 ++++++++
 tb/tb_pc_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the instruction-fetch PC generator: next-PC source
// codes and the redirect-alignment mask.
package pc_pkg;

  typedef logic [2:0] pc_src_t;

  localparam pc_src_t PC_SRC_SEQ      = 3'd0;
  localparam pc_src_t PC_SRC_HOLD     = 3'd1;
  localparam pc_src_t PC_SRC_RET      = 3'd2;
  localparam pc_src_t PC_SRC_REDIRECT = 3'd3;
  localparam pc_src_t PC_SRC_TRAP     = 3'd4;

  // Mask that clears the byte-offset bits inside one instruction.
  function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
    return ~(64'(instr_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// entry count; pushing while full silently replaces the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [XLEN-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path can infer a latch.
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (push_i && do_pop) begin
      // Call and return together: replace the top in place.
      mem_d[ptr_q] = push_data_i;
    end else if (push_i) begin
      ptr_d        = ptr_q + PW'(1);
      mem_d[ptr_d] = push_data_i;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      // NOTE: the storage is cleared too, so reset genuinely discards entries and top_o is never X.
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: prioritised next-PC selection
// (trap, redirect, stall, return, sequential) with a return-address stack.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_underflow_o
);

  localparam logic [63:0]     ALIGN_FULL = align_mask(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN      = ALIGN_FULL[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic            underflow_q, underflow_d;
  logic [XLEN-1:0] ras_top;
  pc_src_t         src;

  always_comb begin
    src         = PC_SRC_SEQ;
    pc_d        = pc_q + XLEN'(INSTR_BYTES);
    underflow_d = 1'b0;
    if (trap_i)                      src = PC_SRC_TRAP;
    else if (redirect_i)             src = PC_SRC_REDIRECT;
    else if (stall_i)                src = PC_SRC_HOLD;
    else if (ret_i && !ras_empty_o)  src = PC_SRC_RET;

    case (src)
      PC_SRC_TRAP:     pc_d = TRAP_VECTOR;
      PC_SRC_REDIRECT: pc_d = redirect_pc_i & ALIGN;
      PC_SRC_HOLD:     pc_d = pc_q;
      PC_SRC_RET:      pc_d = ras_top;
      default:         underflow_d = ret_i;  // only reached with an empty stack
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_VECTOR;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      valid_q     <= 1'b1;
      underflow_q <= underflow_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i && !trap_i),
    .pop_i       (src == PC_SRC_RET),
    .flush_i     (trap_i),
    .push_data_i (push_addr_i),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o)
  );

  assign pc_o            = pc_q;
  assign pc_valid_o      = valid_q;
  assign ras_underflow_o = underflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch PC and RAS.
module tb_pc_gen;

  localparam int RAS_DEPTH = 4;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i, trap_i, redirect_i, push_i, ret_i;
  logic [31:0] redirect_pc_i, push_addr_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, ras_empty_o, ras_full_o, ras_underflow_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_valid, m_uf;
  logic [31:0] m_q[$];

  pc_gen dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .trap_i          (trap_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .push_i          (push_i),
    .push_addr_i     (push_addr_i),
    .ret_i           (ret_i),
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
    .ras_empty_o     (ras_empty_o),
    .ras_full_o      (ras_full_o),
    .ras_underflow_o (ras_underflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_uf    = 1'b0;
    m_q.delete();
  endtask

  // Apply one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic cycle(input bit st, input bit tr, input bit rd, input logic [31:0] rpc,
                       input bit ps, input logic [31:0] pa, input bit rt);
    logic [31:0] npc;
    bit          popped;
    bit          uf;
    stall_i = st; trap_i = tr; redirect_i = rd; redirect_pc_i = rpc;
    push_i = ps; push_addr_i = pa; ret_i = rt;
    popped = 1'b0;
    uf     = 1'b0;
    if (tr) begin
      npc = 32'h100;
      m_q.delete();
    end else begin
      if (rd)                          npc = {rpc[31:2], 2'b00};
      else if (st)                     npc = m_pc;
      else if (rt && m_q.size() > 0) begin
        npc    = m_q[m_q.size()-1];
        popped = 1'b1;
      end else begin
        npc = m_pc + 32'd4;
        uf  = rt;
      end
      if (popped && ps)  m_q[m_q.size()-1] = pa;
      else if (popped)   void'(m_q.pop_back());
      else if (ps) begin
        m_q.push_back(pa);
        if (m_q.size() > RAS_DEPTH) void'(m_q.pop_front());
      end
    end
    @(posedge clk_i);
    m_pc    = npc;
    m_uf    = uf;
    m_valid = 1'b1;
    #1;
  endtask

  task automatic idle();                 cycle(0, 0, 0, 32'h0, 0, 32'h0, 0); endtask
  task automatic push(input logic [31:0] a); cycle(0, 0, 0, 32'h0, 1, a, 0); endtask
  task automatic ret();                  cycle(0, 0, 0, 32'h0, 0, 32'h0, 1); endtask
  task automatic redir(input logic [31:0] a); cycle(0, 0, 1, a, 0, 32'h0, 0); endtask

  task automatic do_reset();
    stall_i = 0; trap_i = 0; redirect_i = 0; push_i = 0; ret_i = 0;
    redirect_pc_i = 0; push_addr_i = 0;
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    stall_i = 0; trap_i = 0; redirect_i = 0; push_i = 0; ret_i = 0;
    redirect_pc_i = 0; push_addr_i = 0;
    rst_i = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (pc_o !== 32'h0 || pc_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: pc=%h valid=%b expected pc=0 valid=0", i, pc_o, pc_valid_o);
      end
    end
    checks++;
    if (ras_empty_o !== 1'b1 || ras_full_o !== 1'b0 || ras_underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ras: empty=%b full=%b uf=%b expected 1 0 0", ras_empty_o, ras_full_o, ras_underflow_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: pc=%h valid=%b expected pc=0 valid=0", pc_o, pc_valid_o);
    end
    idle();
    checks++;
    if (pc_o !== 32'h4 || pc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge: pc=%h valid=%b expected pc=4 valid=1", pc_o, pc_valid_o);
    end
    idle();
    checks++;
    if (pc_o !== 32'h8 || pc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_second_edge: pc=%h valid=%b expected pc=8 valid=1", pc_o, pc_valid_o);
    end
  endtask

  task automatic test_stall_redirect();
    redir(32'h10);
    checks++;
    if (pc_o !== 32'h10) begin
      failures++;
      $display("FAIL redirect_setup: pc=%h expected 00000010", pc_o);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 32'h0, 0, 32'h0, 0);
      checks++;
      if (pc_o !== 32'h10) begin
        failures++;
        $display("FAIL stall_hold[%0d]: pc=%h expected 00000010", i, pc_o);
      end
    end
    cycle(1, 0, 1, 32'h203, 0, 32'h0, 0);
    checks++;
    if (pc_o !== 32'h200) begin
      failures++;
      $display("FAIL redirect_over_stall: pc=%h expected 00000200", pc_o);
    end
  endtask

  task automatic test_ras_round_trip();
    do_reset();
    push(32'h40);
    push(32'h80);
    ret();
    checks++;
    if (pc_o !== 32'h80 || ras_empty_o !== 1'b0) begin
      failures++;
      $display("FAIL ras_ret1: pc=%h empty=%b expected pc=00000080 empty=0", pc_o, ras_empty_o);
    end
    ret();
    checks++;
    if (pc_o !== 32'h40 || ras_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL ras_ret2: pc=%h empty=%b expected pc=00000040 empty=1", pc_o, ras_empty_o);
    end
    ret();
    checks++;
    if (pc_o !== 32'h44 || ras_underflow_o !== 1'b1) begin
      failures++;
      $display("FAIL ras_underflow: pc=%h uf=%b expected pc=00000044 uf=1", pc_o, ras_underflow_o);
    end
    idle();
    checks++;
    if (pc_o !== 32'h48 || ras_underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL ras_underflow_pulse: pc=%h uf=%b expected pc=00000048 uf=0", pc_o, ras_underflow_o);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h110; exp_ret[1] = 32'h10C; exp_ret[2] = 32'h108; exp_ret[3] = 32'h104;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(32'h100 + 32'(4 * i));
      if (i == 3) begin
        checks++;
        if (ras_full_o !== 1'b1) begin
          failures++;
          $display("FAIL ras_full_at_depth: full=%b expected 1", ras_full_o);
        end
      end
    end
    checks++;
    if (ras_full_o !== 1'b1 || ras_empty_o !== 1'b0) begin
      failures++;
      $display("FAIL ras_full_overflow: full=%b empty=%b expected 1 0", ras_full_o, ras_empty_o);
    end
    for (int i = 0; i < 4; i++) begin
      ret();
      checks++;
      if (pc_o !== exp_ret[i]) begin
        failures++;
        $display("FAIL ras_overflow_ret[%0d]: pc=%h expected %h", i, pc_o, exp_ret[i]);
      end
    end
    checks++;
    if (ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) begin
      failures++;
      $display("FAIL ras_drained: empty=%b full=%b expected 1 0", ras_empty_o, ras_full_o);
    end
  endtask

  task automatic test_trap_priority();
    do_reset();
    push(32'h500);
    push(32'h600);
    cycle(0, 1, 1, 32'h300, 1, 32'h700, 1);
    checks++;
    if (pc_o !== 32'h100 || ras_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL trap_priority: pc=%h empty=%b expected pc=00000100 empty=1", pc_o, ras_empty_o);
    end
    ret();
    checks++;
    if (pc_o !== 32'h104 || ras_underflow_o !== 1'b1 || ras_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL trap_no_push: pc=%h uf=%b empty=%b expected pc=00000104 uf=1 empty=1",
               pc_o, ras_underflow_o, ras_empty_o);
    end
  endtask

  task automatic test_wrap_async_reset();
    redir(32'hFFFF_FFFC);
    idle();
    checks++;
    if (pc_o !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: pc=%h expected 00000000", pc_o);
    end
    push(32'h20);
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || ras_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: pc=%h valid=%b empty=%b expected pc=0 valid=0 empty=1",
               pc_o, pc_valid_o, ras_empty_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
            $urandom(), $urandom_range(0, 2) == 0, $urandom() & 32'hFFFF_FFFC,
            $urandom_range(0, 2) == 0);
      checks++;
      if (pc_o !== m_pc || pc_valid_o !== m_valid || ras_underflow_o !== m_uf ||
          ras_empty_o !== (m_q.size() == 0) || ras_full_o !== (m_q.size() == RAS_DEPTH)) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: pc=%h valid=%b uf=%b empty=%b full=%b expected pc=%h valid=%b uf=%b depth=%0d",
                   n, pc_o, pc_valid_o, ras_underflow_o, ras_empty_o, ras_full_o,
                   m_pc, m_valid, m_uf, m_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_ras_round_trip();
    test_ras_overflow();
    test_trap_priority();
    test_wrap_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
